// File: rtl/difftest_step_scheduler.sv
// difftest_step_scheduler: batches per-cycle commit step counts into single
// outstanding nstep requests, tracks the sticky checker result and throttles
// the core before the step accumulator can overflow.
module difftest_step_scheduler #(
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 16,
    parameter int BATCH   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [STEP_W-1:0] step_in,
    input  logic              flush,
    output logic              step_stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [CNT_W-1:0]  req_nstep,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_result,
    output logic [7:0]        simv_result,
    output logic              perf_dump,
    output logic              busy,
    output logic              proto_err
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  BATCH_V   = CNT_W'(BATCH);
    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);
    // 2^CNT_W - 2^(STEP_W+1), written as the complement of the low mask
    localparam logic [CNT_W-1:0]  STALL_TH  = ~CNT_W'((1 << (STEP_W + 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HALT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    acc;
    logic [CNT_W-1:0]    acc_next;
    logic [CNT_W:0]      acc_sum;
    logic                acc_ovf;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                launch;
    logic [CNT_W-1:0]    nstep_r;
    logic [7:0]          simv_r;
    logic                proto_r;
    logic                stall_r;

    // Saturating accumulator update, launch decision and next-state logic
    always_comb begin
        acc_sum    = {1'b0, acc} + (CNT_W + 1)'(step_in);
        acc_ovf    = 1'b0;
        acc_next   = acc;
        launch     = 1'b0;
        state_next = state;
        if (state != S_HALT) begin
            acc_ovf  = acc_sum[CNT_W];
            acc_next = acc_ovf ? '1 : acc_sum[CNT_W-1:0];
        end
        case (state)
            S_IDLE: begin
                launch = (acc_next >= BATCH_V)
                       || (flush && (acc_next != '0))
                       || ((TIMEOUT != 0) && (idle_cnt >= TIMEOUT_V) && (acc != '0));
                if (launch) state_next = S_REQ;
            end
            S_REQ: begin
                if (req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_valid) state_next = (rsp_result == 8'd0) ? S_IDLE : S_HALT;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // State, accumulator, idle counter, request payload and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            idle_cnt <= '0;
            nstep_r  <= '0;
            simv_r   <= '0;
            proto_r  <= 1'b0;
            stall_r  <= 1'b0;
        end else begin
            state   <= state_next;
            stall_r <= (acc_next >= STALL_TH) || (state_next == S_HALT);
            if (acc_ovf || (rsp_valid && (state != S_WAIT))) proto_r <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        nstep_r  <= acc_next;
                        acc      <= '0;
                        idle_cnt <= '0;
                    end else begin
                        acc <= acc_next;
                        if (acc_next == '0) idle_cnt <= '0;
                        else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    acc      <= acc_next;
                    idle_cnt <= '0;
                end
                S_WAIT: begin
                    acc      <= acc_next;
                    idle_cnt <= '0;
                    if (rsp_valid && (rsp_result != 8'd0)) simv_r <= rsp_result;
                end
                default: ;
            endcase
        end
    end

    assign req_valid   = (state == S_REQ);
    assign req_nstep   = nstep_r;
    assign step_stall  = stall_r;
    assign simv_result = simv_r;
    assign perf_dump   = (simv_r != 8'd0);
    assign busy        = (state != S_IDLE) || (acc != '0);
    assign proto_err   = proto_r;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Testbench for difftest_step_scheduler: instance A uses default parameters,
// instance B uses CNT_W=10 and TIMEOUT=8. Requests are checked by a
// scoreboard monitor; sticky outputs are checked directly by the stimulus.
module tb_difftest_step_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [7:0]  a_step_in = '0, b_step_in = '0;
    logic        a_flush = 1'b0, b_flush = 1'b0;
    logic        a_req_ready = 1'b0, b_req_ready = 1'b0;
    logic        a_rsp_valid = 1'b0, b_rsp_valid = 1'b0;
    logic [7:0]  a_rsp_result = '0, b_rsp_result = '0;
    logic        a_step_stall, b_step_stall;
    logic        a_req_valid, b_req_valid;
    logic [15:0] a_req_nstep;
    logic [9:0]  b_req_nstep;
    logic [7:0]  a_simv_result, b_simv_result;
    logic        a_perf_dump, b_perf_dump;
    logic        a_busy, b_busy;
    logic        a_proto_err, b_proto_err;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [15:0] nstep;
        int unsigned cyc;
    } exp_t;
    exp_t aq[$];
    exp_t bq[$];

    difftest_step_scheduler dut_a (
        .clock(clock), .reset(reset), .step_in(a_step_in), .flush(a_flush),
        .step_stall(a_step_stall), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_nstep(a_req_nstep), .rsp_valid(a_rsp_valid), .rsp_result(a_rsp_result),
        .simv_result(a_simv_result), .perf_dump(a_perf_dump), .busy(a_busy),
        .proto_err(a_proto_err)
    );

    difftest_step_scheduler #(.STEP_W(8), .CNT_W(10), .BATCH(64), .TIMEOUT(8)) dut_b (
        .clock(clock), .reset(reset), .step_in(b_step_in), .flush(b_flush),
        .step_stall(b_step_stall), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_nstep(b_req_nstep), .rsp_valid(b_rsp_valid), .rsp_result(b_rsp_result),
        .simv_result(b_simv_result), .perf_dump(b_perf_dump), .busy(b_busy),
        .proto_err(b_proto_err)
    );

    always #5 clock = ~clock;

    // Cycle index: value after the N-th rising edge is N
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: pops on each request rise, checks payload stability
    logic        a_prev_v = 1'b0, b_prev_v = 1'b0;
    logic [15:0] a_prev_n = '0;
    logic [9:0]  b_prev_n = '0;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (a_req_valid && !a_prev_v) begin
                if (aq.size() == 0) chk("a_unexpected_request", 1, 0);
                else begin
                    e = aq.pop_front();
                    chk("a_req_nstep", a_req_nstep, e.nstep);
                    chk("a_req_rise_cycle", cyc, e.cyc);
                end
            end else if (a_req_valid && a_prev_v) begin
                chk("a_req_nstep_stable", a_req_nstep, a_prev_n);
            end
            if (b_req_valid && !b_prev_v) begin
                if (bq.size() == 0) chk("b_unexpected_request", 1, 0);
                else begin
                    e = bq.pop_front();
                    chk("b_req_nstep", b_req_nstep, e.nstep);
                    chk("b_req_rise_cycle", cyc, e.cyc);
                end
            end else if (b_req_valid && b_prev_v) begin
                chk("b_req_nstep_stable", b_req_nstep, b_prev_n);
            end
        end
        a_prev_v = a_req_valid;
        a_prev_n = a_req_nstep;
        b_prev_v = b_req_valid;
        b_prev_n = b_req_nstep;
    end

    initial begin
        int unsigned c;

        // Reset state
        repeat (2) tick();
        chk("a_reset_req_valid", a_req_valid, 0);
        chk("a_reset_busy", a_busy, 0);
        chk("a_reset_stall", a_step_stall, 0);
        chk("a_reset_simv", a_simv_result, 0);
        chk("a_reset_perf", a_perf_dump, 0);
        chk("a_reset_proto", a_proto_err, 0);
        chk("a_reset_nstep", a_req_nstep, 0);
        chk("b_reset_req_valid", b_req_valid, 0);
        chk("b_reset_busy", b_busy, 0);
        reset = 1'b0;

        // Batch launch: 4 steps/cycle reaches 64 on the 16th edge
        a_req_ready = 1'b1;
        c = cyc;
        aq.push_back('{16'd64, c + 16});
        a_step_in = 8'd4;
        repeat (16) tick();
        a_step_in = 8'd0;
        chk("a_batch_req_valid", a_req_valid, 1);
        tick();
        chk("a_batch_handshake_drop", a_req_valid, 0);
        a_rsp_valid = 1'b1; a_rsp_result = 8'd0;
        tick();
        a_rsp_valid = 1'b0;
        chk("a_batch_idle_busy", a_busy, 0);
        chk("a_batch_proto", a_proto_err, 0);

        // Timeout launch: 3 steps then 8 idle cycles
        b_req_ready = 1'b1;
        c = cyc;
        bq.push_back('{16'd3, c + 9});
        b_step_in = 8'd3;
        tick();
        b_step_in = 8'd0;
        repeat (7) tick();
        chk("b_timeout_not_yet", b_req_valid, 0);
        tick();
        chk("b_timeout_req_valid", b_req_valid, 1);
        tick();
        b_rsp_valid = 1'b1; b_rsp_result = 8'd0;
        tick();
        b_rsp_valid = 1'b0;
        // Flush launch: issued the next cycle
        c = cyc;
        bq.push_back('{16'd3, c + 1});
        b_flush = 1'b1; b_step_in = 8'd3;
        tick();
        b_flush = 1'b0; b_step_in = 8'd0;
        chk("b_flush_req_valid", b_req_valid, 1);
        tick();
        b_rsp_valid = 1'b1;
        tick();
        b_rsp_valid = 1'b0;
        chk("b_flush_idle_busy", b_busy, 0);

        // Back-pressure: request held for 5 cycles while 2 steps/cycle accumulate
        a_req_ready = 1'b0;
        c = cyc;
        aq.push_back('{16'd5, c + 1});
        a_flush = 1'b1; a_step_in = 8'd5;
        tick();
        a_flush = 1'b0; a_step_in = 8'd2;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("a_hold_req_valid", a_req_valid, 1);
        end
        a_step_in = 8'd0; a_req_ready = 1'b1;
        tick();
        a_req_ready = 1'b0;
        chk("a_hold_handshake_drop", a_req_valid, 0);
        a_rsp_valid = 1'b1; a_rsp_result = 8'd0;
        tick();
        a_rsp_valid = 1'b0;
        chk("a_hold_pending_busy", a_busy, 1);
        c = cyc;
        aq.push_back('{16'd10, c + 1});
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_req_ready = 1'b1;
        tick();
        a_req_ready = 1'b0;

        // FAIL response in WAIT: halt with sticky result
        a_rsp_valid = 1'b1; a_rsp_result = 8'h2;
        tick();
        a_rsp_valid = 1'b0;
        chk("a_halt_simv", a_simv_result, 2);
        chk("a_halt_perf", a_perf_dump, 1);
        chk("a_halt_stall", a_step_stall, 1);
        chk("a_halt_proto", a_proto_err, 0);
        a_step_in = 8'd100; a_rsp_valid = 1'b1; a_rsp_result = 8'h1;
        tick();
        a_rsp_valid = 1'b0;
        repeat (3) tick();
        a_step_in = 8'd0;
        chk("a_halt_simv_held", a_simv_result, 2);
        chk("a_halt_stray_rsp_proto", a_proto_err, 1);
        chk("a_halt_no_request", a_req_valid, 0);
        chk("a_halt_stall_held", a_step_stall, 1);

        // Stall threshold with CNT_W=10: high once acc_next reaches 512
        b_req_ready = 1'b0;
        c = cyc;
        bq.push_back('{16'd255, c + 1});
        b_step_in = 8'd255;
        for (int unsigned i = 1; i <= 4; i++) begin
            tick();
            chk("b_stall_ramp", b_step_stall, (i == 4) ? 1 : 0);
            if (b_step_stall) b_step_in = 8'd0;
        end
        b_step_in = 8'd0;
        repeat (2) tick();
        chk("b_stall_held", b_step_stall, 1);
        chk("b_stall_no_overflow", b_proto_err, 0);
        b_req_ready = 1'b1;
        tick();
        b_req_ready = 1'b0;
        b_rsp_valid = 1'b1; b_rsp_result = 8'd0;
        c = cyc;
        bq.push_back('{16'd765, c + 2});
        tick();
        b_rsp_valid = 1'b0;
        tick();
        chk("b_relaunch_req_valid", b_req_valid, 1);
        b_req_ready = 1'b1;
        tick();
        b_req_ready = 1'b0;
        chk("b_final_proto", b_proto_err, 0);

        // Protocol error and reset mid-request
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("a_rereset_simv", a_simv_result, 0);
        chk("a_rereset_proto", a_proto_err, 0);
        chk("a_rereset_stall", a_step_stall, 0);
        a_rsp_valid = 1'b1; a_rsp_result = 8'd0;
        tick();
        a_rsp_valid = 1'b0;
        chk("a_idle_rsp_proto", a_proto_err, 1);
        chk("a_idle_rsp_no_halt", a_perf_dump, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c = cyc;
        aq.push_back('{16'd7, c + 1});
        a_flush = 1'b1; a_step_in = 8'd7;
        tick();
        a_flush = 1'b0; a_step_in = 8'd3;
        tick();
        a_step_in = 8'd0;
        chk("a_req_before_reset", a_req_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("a_reset_in_req_valid", a_req_valid, 0);
        chk("a_reset_in_req_busy", a_busy, 0);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        tick();
        chk("a_flush_empty_no_req", a_req_valid, 0);

        chk("a_scoreboard_drained", aq.size(), 0);
        chk("b_scoreboard_drained", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
